fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single active-low write port of fifo_top between NUM_CH event-producing channels using round-robin arbitration.
- Guarantees that no write is issued that would overflow the FIFO.
- Inserts chip_id/timestamp-tagged test words when test_mode is set.
- Sits between the channel digitizer/packetizer outputs and fifo_top's data_in/write_n inputs.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- FIFO_WIDTH, 64, word width; test-word packing requires exactly 64.
- FIFO_DEPTH, 2048, FIFO capacity in words.
- FIFO_BITS, 11, log2(FIFO_DEPTH); fifo_counter width is FIFO_BITS+1.
- TEST_INTERVAL, 256, cycles between test words in test mode (>=2).

Ports:
- clk  input  1  master clock.
- reset  input  1  synchronous reset, active-high.
- ch_valid  input  NUM_CH  channel i holds a word; stays high until acked.
- ch_data  input  NUM_CH*FIFO_WIDTH  channel words; channel i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- ch_lowpri  input  NUM_CH  static config; channel masked while fifo_half is high.
- ch_ack  output  NUM_CH  one-cycle pulse: channel word has been written.
- test_mode  input  1  high: channels ignored, test words generated.
- chip_id  input  8  test-word tag.
- timestamp_32b  input  32  test-word tag.
- fifo_counter  input  FIFO_BITS+1  from fifo_top.
- fifo_full  input  1  from fifo_top.
- fifo_half  input  1  from fifo_top.
- fifo_data_in  output  FIFO_WIDTH  to fifo_top data_in.
- fifo_write_n  output  1  to fifo_top write_n, active-low.
- stall_count  output  16  saturating count of blocked cycles.

Behaviour:
- Reset values (synchronous, active-high): fifo_write_n=1, fifo_data_in=0, ch_ack=0, stall_count=0, rr pointer=0, test seq=0, interval counter=0, test pending=0.
- All outputs are registered.
- Space check: space_ok = !fifo_full && !(fifo_write_n==0 && fifo_counter==FIFO_DEPTH-1). This accounts for one write already in flight.
- Eligibility: eligible[i] = ch_valid[i] && !ch_ack[i] && !(fifo_half && ch_lowpri[i]) && !test_mode.
  - The !ch_ack[i] term blocks a regrant while the requester is still retiring its acked word.
  - Consequence: a single channel writes at most every 2nd cycle; different channels may write back-to-back.
- Grant in cycle t when space_ok and any eligible[i]:
  - Winner is the first eligible index at or after the rr pointer, wrapping modulo NUM_CH.
  - Cycle t+1: fifo_write_n=0, fifo_data_in=ch_data[winner], ch_ack[winner]=1.
  - rr pointer becomes winner+1 mod NUM_CH.
- If there is no grant in cycle t, then in t+1: fifo_write_n=1, ch_ack=0, fifo_data_in holds its last value.
- Requester rule: ch_data must be stable while ch_valid=1 and ack=0. The requester may present the next word in the cycle after ack.
- Stall: stall_count increments in any cycle where any eligible[i] is set and space_ok=0. It saturates at 0xFFFF.
- Test mode:
  - Interval counter counts 0..TEST_INTERVAL-1 and wraps. At wrap, test pending is set.
  - When pending and space_ok, the word {chip_id, timestamp_32b, seq[23:0]} (MSB to LSB) is written next cycle.
  - On that write: pending clears and seq increments, wrapping at 2^24.
  - A pending word is never dropped; it is delayed while full. A second wrap while still pending does not queue a second word.
- test_mode transitions:
  - Entering test_mode: channel acks stop immediately. An ack already registered still completes.
  - Leaving test_mode: pending is cleared. Interval counter and seq hold their values.
- Reset mid-operation: any registered write or ack is squashed; fifo_write_n=1 the cycle after reset is sampled. Requesters keep ch_valid and are re-served after reset.
- fifo_counter is trusted to be consistent with fifo_full. If they disagree, fifo_full wins (no write).

Decomposition:
- Package fifo_arb_pkg:
  - localparam TEST_SEQ_BITS=24.
  - function pack_test_word(chip_id, timestamp, seq).
  - function rr_pick(eligible, ptr) returning index plus a valid flag.
- Sub-module rr_arbiter (parameter N): combinational pick plus registered pointer. It is reusable for the readout side.

Test Plan:
- Single channel 0 valid with data 0xDEAD_BEEF_0000_0001, FIFO empty -> write_n low for exactly 1 cycle at t+1 with that data; ch_ack[0] pulses once; no regrant.
- All 4 channels continuously valid, FIFO empty -> acks in order 0,1,2,3,0,...; one write per cycle; each channel acked exactly every 4 cycles.
- fifo_counter=2047 with a write in flight, then fifo_full=1 -> no write issued; stall_count increments each cycle; grants resume the cycle after fifo_full drops and counter is <2047.
- ch_lowpri=4'b1100, fifo_half=1, all valid -> only channels 0 and 1 acked; channels 2 and 3 are acked again once fifo_half=0.
- test_mode=1, TEST_INTERVAL=256, chip_id=0x5A, timestamp=0x12345678 -> word 0x5A12345678000000, then seq 1, 2 at 256-cycle spacing; with full held for 300 cycles, exactly one delayed word and seq continuity.
- Reset asserted in the cycle a grant is made -> fifo_write_n stays 1, no ack, stall_count=0, rr pointer=0 afterwards.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write arbiter and its round-robin
// arbiter. It provides the test-word layout and a generic round-robin pick
// over up to RR_MAX_N requesters.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int TEST_SEQ_BITS = 24;
    localparam int RR_MAX_N      = 16;
    localparam int RR_IDX_W      = 4;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Test word layout, MSB to LSB: chip_id, timestamp, sequence number.
    function automatic logic [63:0] pack_test_word(
        input logic [7:0]               chip_id,
        input logic [31:0]              timestamp,
        input logic [TEST_SEQ_BITS-1:0] seq
    );
        return {chip_id, timestamp, seq};
    endfunction

    // First set bit of eligible[n-1:0] at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_N-1:0] eligible,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        rr_pick_t pick;
        int       j;
        pick = '0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !pick.valid && eligible[j[RR_IDX_W-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = RR_IDX_W'(j);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: a combinational pick starting at a registered pointer.
// The pointer moves past the winner only when the caller takes the grant.
//   clk, reset   clock, synchronous active-high reset
//   req          request vector
//   advance      caller accepts the current pick this cycle
//   grant_valid  some request is present
//   grant_idx    index of the picked requester
// -----------------------------------------------------------------------------
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    rr_pick_t         pick;
    int               nxt;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        pick  = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr_q), N);
        nxt   = int'(pick.idx) + 1;
        ptr_d = ptr_q;
        if (advance && pick.valid) begin
            ptr_d = (nxt == N) ? '0 : IDX_W'(nxt);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_valid = pick.valid;
    assign grant_idx   = pick.idx[IDX_W-1:0];

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Shares fifo_top's single active-low write port between NUM_CH channels
// using round-robin arbitration. It never overflows the FIFO and, in test
// mode, injects chip_id/timestamp-tagged words at a fixed interval.
//   ch_valid/ch_data/ch_ack   per-channel request, word, one-cycle ack
//   ch_lowpri                 channels masked while fifo_half is high
//   test_mode/chip_id/timestamp_32b   test-word generation controls
//   fifo_counter/full/half    FIFO status from fifo_top
//   fifo_data_in/fifo_write_n registered write port to fifo_top
//   stall_count               saturating count of blocked cycles
// -----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int FIFO_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 2048,
    parameter int FIFO_BITS     = 11,
    parameter int TEST_INTERVAL = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*FIFO_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_lowpri,
    output logic [NUM_CH-1:0]            ch_ack,
    input  logic                         test_mode,
    input  logic [7:0]                   chip_id,
    input  logic [31:0]                  timestamp_32b,
    input  logic [FIFO_BITS:0]           fifo_counter,
    input  logic                         fifo_full,
    input  logic                         fifo_half,
    output logic [FIFO_WIDTH-1:0]        fifo_data_in,
    output logic                         fifo_write_n,
    output logic [15:0]                  stall_count
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int INT_W = $clog2(TEST_INTERVAL);
    localparam int CNT_W = FIFO_BITS + 1;
    localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(FIFO_DEPTH - 1);

    logic                     write_n_q, write_n_d;
    logic [FIFO_WIDTH-1:0]    data_q, data_d;
    logic [NUM_CH-1:0]        ack_q, ack_d;
    logic [15:0]              stall_q, stall_d;
    logic [TEST_SEQ_BITS-1:0] seq_q, seq_d;
    logic [INT_W-1:0]         interval_q, interval_d;
    logic                     pending_q, pending_d;

    logic              space_ok, ch_grant, test_write, wrap, pick_valid;
    logic [NUM_CH-1:0] eligible;
    logic [IDX_W-1:0]  pick_idx;

    // A write registered last cycle lands this cycle, so a counter one short
    // of full already counts as full. fifo_full alone always blocks.
    assign space_ok = !fifo_full && !(!write_n_q && fifo_counter == LAST_FREE);

    // Masking by ack_q stops a channel being regranted while it retires the
    // word that was just acked.
    assign eligible = ch_valid & ~ack_q & ~(ch_lowpri & {NUM_CH{fifo_half}})
                    & {NUM_CH{!test_mode}};

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (eligible),
        .advance     (space_ok),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign ch_grant   = space_ok && pick_valid;
    assign test_write = test_mode && pending_q && space_ok;
    assign wrap       = test_mode && interval_q == INT_W'(TEST_INTERVAL - 1);

    always_comb begin
        write_n_d  = 1'b1;
        ack_d      = '0;
        data_d     = data_q;
        stall_d    = stall_q;
        seq_d      = seq_q;
        interval_d = interval_q;
        pending_d  = 1'b0;

        if (ch_grant) begin
            write_n_d       = 1'b0;
            data_d          = ch_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
            ack_d[pick_idx] = 1'b1;
        end else if (test_write) begin
            write_n_d = 1'b0;
            data_d    = pack_test_word(chip_id, timestamp_32b, seq_q);
            seq_d     = seq_q + 1'b1;
        end

        if (|eligible && !space_ok && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end

        // Interval and sequence freeze outside test mode; pending does not
        // survive leaving it, and a wrap while pending queues nothing more.
        if (test_mode) begin
            interval_d = wrap ? '0 : interval_q + INT_W'(1);
            pending_d  = pending_q ? !test_write : wrap;
        end
    end

    // NOTE: data_q is reset too so fifo_data_in is defined from the first
    // cycle; it otherwise holds its last value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_n_q  <= 1'b1;
            data_q     <= '0;
            ack_q      <= '0;
            stall_q    <= '0;
            seq_q      <= '0;
            interval_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            write_n_q  <= write_n_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            stall_q    <= stall_d;
            seq_q      <= seq_d;
            interval_q <= interval_d;
            pending_q  <= pending_d;
        end
    end

    assign fifo_write_n = write_n_q;
    assign fifo_data_in = data_q;
    assign ch_ack       = ack_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter: reset state, single requester,
// round-robin order, space/full blocking with stall counting, low-priority
// masking, reset during a grant, and test-word generation with a long stall.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;
    localparam int NUM_CH     = 4;
    localparam int FIFO_WIDTH = 64;
    localparam int FIFO_BITS  = 11;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH*FIFO_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_lowpri;
    logic [NUM_CH-1:0]            ch_ack;
    logic                         test_mode;
    logic [7:0]                   chip_id;
    logic [31:0]                  timestamp_32b;
    logic [FIFO_BITS:0]           fifo_counter;
    logic                         fifo_full;
    logic                         fifo_half;
    logic [FIFO_WIDTH-1:0]        fifo_data_in;
    logic                         fifo_write_n;
    logic [15:0]                  stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_CH(NUM_CH), .FIFO_WIDTH(FIFO_WIDTH), .FIFO_DEPTH(2048),
        .FIFO_BITS(FIFO_BITS), .TEST_INTERVAL(256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_lowpri     (ch_lowpri),
        .ch_ack        (ch_ack),
        .test_mode     (test_mode),
        .chip_id       (chip_id),
        .timestamp_32b (timestamp_32b),
        .fifo_counter  (fifo_counter),
        .fifo_full     (fifo_full),
        .fifo_half     (fifo_half),
        .fifo_data_in  (fifo_data_in),
        .fifo_write_n  (fifo_write_n),
        .stall_count   (stall_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until a write appears or the budget runs out; n is steps taken.
    task automatic wait_write(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (fifo_write_n !== 1'b0 && n < limit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;

        reset         = 1'b1;
        ch_valid      = '0;
        ch_data       = '0;
        ch_lowpri     = '0;
        test_mode     = 1'b0;
        chip_id       = 8'h5A;
        timestamp_32b = 32'h1234_5678;
        fifo_counter  = '0;
        fifo_full     = 1'b0;
        fifo_half     = 1'b0;
        step();
        step();
        check("rst_write_n", 64'(fifo_write_n), 64'(1));
        check("rst_data",    fifo_data_in,      64'h0);
        check("rst_ack",     64'(ch_ack),       64'(0));
        check("rst_stall",   64'(stall_count),  64'(0));

        // Single requester: one write, one ack, no regrant while retiring.
        reset           = 1'b0;
        ch_data[63:0]   = 64'hDEAD_BEEF_0000_0001;
        ch_valid        = 4'b0001;
        step();
        check("single_write_n", 64'(fifo_write_n), 64'(0));
        check("single_data",    fifo_data_in,      64'hDEAD_BEEF_0000_0001);
        check("single_ack",     64'(ch_ack),       64'(4'b0001));
        step();
        check("single_gap_write_n", 64'(fifo_write_n), 64'(1));
        check("single_gap_ack",     64'(ch_ack),       64'(0));
        check("single_data_hold",   fifo_data_in,      64'hDEAD_BEEF_0000_0001);
        ch_valid = '0;
        step();
        check("single_idle_write_n", 64'(fifo_write_n), 64'(1));

        // Round robin with every channel busy, from a fresh pointer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) ch_data[i*FIFO_WIDTH +: FIFO_WIDTH] = 64'h1000 + 64'(i);
        ch_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_write_n", 64'(fifo_write_n), 64'(0));
            check("rr_ack",     64'(ch_ack),       64'(1) << (i % 4));
            check("rr_data",    fifo_data_in,      64'h1000 + 64'(i % 4));
        end

        // One slot left but a write is in flight: blocked, stall counts.
        fifo_counter = 12'd2047;
        step();
        check("inflight_write_n", 64'(fifo_write_n), 64'(1));
        check("inflight_ack",     64'(ch_ack),       64'(0));
        check("inflight_stall",   64'(stall_count),  64'(1));
        // fifo_full blocks even with an inconsistent low counter.
        fifo_full    = 1'b1;
        fifo_counter = '0;
        step();
        step();
        step();
        check("full_write_n", 64'(fifo_write_n), 64'(1));
        check("full_stall",   64'(stall_count),  64'(4));
        fifo_full    = 1'b0;
        fifo_counter = 12'd2046;
        step();
        check("resume_write_n", 64'(fifo_write_n), 64'(0));
        check("resume_ack",     64'(ch_ack),       64'(4'b0001));
        check("resume_stall",   64'(stall_count),  64'(4));
        fifo_counter = 12'd2047;
        step();
        check("last_slot_write_n", 64'(fifo_write_n), 64'(1));
        check("last_slot_stall",   64'(stall_count),  64'(5));
        fifo_counter = '0;
        step();
        check("after_stall_ack", 64'(ch_ack), 64'(4'b0010));

        // Low-priority masking: only 0 and 1 while half, then 2 and 3.
        ch_lowpri = 4'b1100;
        fifo_half = 1'b1;
        step(); check("lowpri_ack_a", 64'(ch_ack), 64'(4'b0001));
        step(); check("lowpri_ack_b", 64'(ch_ack), 64'(4'b0010));
        step(); check("lowpri_ack_c", 64'(ch_ack), 64'(4'b0001));
        step(); check("lowpri_ack_d", 64'(ch_ack), 64'(4'b0010));
        fifo_half = 1'b0;
        step(); check("lowpri_ack_e", 64'(ch_ack), 64'(4'b0100));
        step(); check("lowpri_ack_f", 64'(ch_ack), 64'(4'b1000));
        check("lowpri_stall", 64'(stall_count), 64'(5));

        // Reset in the cycle a grant would be made.
        reset = 1'b1;
        step();
        check("midrst_write_n", 64'(fifo_write_n), 64'(1));
        check("midrst_ack",     64'(ch_ack),       64'(0));
        check("midrst_stall",   64'(stall_count),  64'(0));
        reset = 1'b0;
        step();
        check("postrst_ack",  64'(ch_ack),     64'(4'b0001));
        check("postrst_data", fifo_data_in,    64'h1000);

        // Test mode: channels ignored, tagged words every 256 cycles.
        test_mode = 1'b1;
        step();
        check("tm_enter_ack",     64'(ch_ack),       64'(0));
        check("tm_enter_write_n", 64'(fifo_write_n), 64'(1));
        wait_write(400, n);
        check("tm_first_delay", 64'(n),       64'(256));
        check("tm_word0",       fifo_data_in, 64'h5A12_3456_7800_0000);
        wait_write(400, n);
        check("tm_second_delay", 64'(n),       64'(256));
        check("tm_word1",        fifo_data_in, 64'h5A12_3456_7800_0001);
        fifo_full = 1'b1;
        w = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (fifo_write_n === 1'b0) w++;
        end
        check("tm_full_writes", 64'(w), 64'(0));
        fifo_full = 1'b0;
        step();
        check("tm_delayed_write_n", 64'(fifo_write_n), 64'(0));
        check("tm_word2",           fifo_data_in,      64'h5A12_3456_7800_0002);
        step();
        check("tm_no_duplicate", 64'(fifo_write_n), 64'(1));
        wait_write(400, n);
        check("tm_third_delay", 64'(n),          64'(210));
        check("tm_word3",       fifo_data_in,    64'h5A12_3456_7800_0003);
        check("tm_stall",       64'(stall_count), 64'(0));

        // Leaving test mode: channel service resumes from the pointer.
        test_mode = 1'b0;
        step();
        check("tm_exit_ack",  64'(ch_ack),  64'(4'b0010));
        check("tm_exit_data", fifo_data_in, 64'h1001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
